fetch_ctrl: RTL and testbench

//   Fetch sequencer in front of the byte-addressed instruction memory. Owns the fetch PC
//   and drives it to the memory, which returns a 5-byte little-endian window combinationally.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_byte_queue.sv | 84 ++++++++
 rtl/fetch_ctrl.sv | 119 +++++++++++
 tb/tb_fetch_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and helpers for the fetch sequencer
package fetch_pkg;

    localparam int         FETCH_WIN_BYTES = 5;
    localparam logic [7:0] NOP_BYTE        = 8'h90;
    localparam int         MAX_INSTR_LEN   = 5;

    typedef logic [8*FETCH_WIN_BYTES-1:0] fetch_win_t;

    // Number of bytes decode can see: queue occupancy clipped to one window.
    function automatic logic [2:0] win_count(input int unsigned cnt);
        if (cnt >= FETCH_WIN_BYTES) begin
            return 3'(FETCH_WIN_BYTES);
        end
        return 3'(cnt);
    endfunction

endpackage

// File: rtl/fetch_byte_queue.sv
// rtl/fetch_byte_queue.sv - circular byte queue with a 5-byte write port and 5-byte read window
module fetch_byte_queue
    import fetch_pkg::*;
#(
    parameter  int BUF_BYTES = 16,
    localparam int PW        = $clog2(BUF_BYTES),
    localparam int CW        = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          wr_en,
    input  fetch_win_t    wr_data,
    input  logic          rd_en,
    input  logic [2:0]    rd_len,
    output logic [CW-1:0] count,
    output logic [CW-1:0] free,
    output fetch_win_t    rd_window
);

    logic [7:0]    mem_q [BUF_BYTES];
    logic [7:0]    mem_d [BUF_BYTES];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] add_bytes, sub_bytes;

    always_comb begin
        mem_d     = mem_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        add_bytes = wr_en ? CW'(FETCH_WIN_BYTES) : '0;
        sub_bytes = rd_en ? CW'(rd_len) : '0;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                for (int i = 0; i < FETCH_WIN_BYTES; i++) begin
                    mem_d[wr_ptr_q + PW'(i)] = wr_data[8*i +: 8];
                end
                wr_ptr_d = wr_ptr_q + PW'(FETCH_WIN_BYTES);
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + PW'(rd_len);
            end
            count_d = count_q + add_bytes - sub_bytes;
        end
    end

    // Storage contents are never observed past count, so they need no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        rd_window = '0;
        for (int i = 0; i < FETCH_WIN_BYTES; i++) begin
            if (CW'(i) < count_q) begin
                rd_window[8*i +: 8] = mem_q[rd_ptr_q + PW'(i)];
            end else begin
                rd_window[8*i +: 8] = NOP_BYTE;
            end
        end
    end

    assign count = count_q;
    assign free  = CW'(BUF_BYTES) - count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch sequencer: PC ownership, fill/consume/redirect arbitration
// Optional bubble counter enabled by defining FETCH_PERF_EN.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int          BUF_BYTES = 16,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_pc,
    input  logic [39:0] imem_instr,
    input  logic        fetch_en,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    output logic [39:0] dec_bytes,
    output logic [2:0]  dec_count,
    output logic [31:0] dec_pc,
    input  logic        dec_consume,
    input  logic [2:0]  dec_len,
    output logic        err_len,
    output logic [31:0] perf_bubbles
);

    localparam int CW = $clog2(BUF_BYTES) + 1;

    logic [CW-1:0] q_count, q_free;
    logic          fill, len_ok, consume_ok;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   dec_pc_q, dec_pc_d;
    logic          err_len_q, err_len_d;

    fetch_byte_queue #(
        .BUF_BYTES (BUF_BYTES)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect),
        .wr_en     (fill),
        .wr_data   (imem_instr),
        .rd_en     (consume_ok),
        .rd_len    (dec_len),
        .count     (q_count),
        .free      (q_free),
        .rd_window (dec_bytes)
    );

    assign dec_count = win_count(int'(q_count));
    assign dec_valid = (q_count != '0);

    // Free space is judged before this cycle's consume so a full queue never overruns.
    always_comb begin
        fill       = fetch_en && !redirect && (q_free >= CW'(FETCH_WIN_BYTES));
        len_ok     = (dec_len != 3'd0) && (dec_len <= dec_count) && (int'(dec_len) <= MAX_INSTR_LEN);
        consume_ok = !redirect && dec_consume && len_ok;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        dec_pc_d   = dec_pc_q;
        err_len_d  = err_len_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            dec_pc_d   = redirect_pc;
            err_len_d  = 1'b0;
        end else begin
            if (fill) begin
                fetch_pc_d = fetch_pc_q + 32'(FETCH_WIN_BYTES);
            end
            if (consume_ok) begin
                dec_pc_d = dec_pc_q + 32'(dec_len);
            end
            if (dec_consume && !len_ok) begin
                err_len_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            dec_pc_q   <= RESET_PC;
            err_len_q  <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            dec_pc_q   <= dec_pc_d;
            err_len_q  <= err_len_d;
        end
    end

    assign imem_pc = fetch_pc_q;
    assign dec_pc  = dec_pc_q;
    assign err_len = err_len_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (!dec_valid && !redirect && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_bubbles = perf_q;
`else
    assign perf_bubbles = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl: vector table, corner sequences, random vs queue model
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_pc;
    logic [39:0] imem_instr;
    logic        fetch_en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic [39:0] dec_bytes;
    logic [2:0]  dec_count;
    logic [31:0] dec_pc;
    logic        dec_consume;
    logic [2:0]  dec_len;
    logic        err_len;
    logic [31:0] perf_bubbles;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.BUF_BYTES(16), .RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_pc      (imem_pc),
        .imem_instr   (imem_instr),
        .fetch_en     (fetch_en),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .dec_valid    (dec_valid),
        .dec_bytes    (dec_bytes),
        .dec_count    (dec_count),
        .dec_pc       (dec_pc),
        .dec_consume  (dec_consume),
        .dec_len      (dec_len),
        .err_len      (err_len),
        .perf_bubbles (perf_bubbles)
    );

    // Memory content: each byte equals the low byte of its address.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        return a[7:0];
    endfunction

    always_comb begin
        imem_instr = '0;
        for (int i = 0; i < 5; i++) imem_instr[8*i +: 8] = mem_byte(imem_pc + 32'(i));
    end

    // Reference model: a plain byte queue plus the two PCs.
    logic [7:0]  mq[$];
    logic [31:0] m_fetch_pc, m_dec_pc, m_perf;
    bit          m_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fetch_pc = 32'h0;
        m_dec_pc   = 32'h0;
        m_err      = 1'b0;
        m_perf     = 32'h0;
    endtask

    task automatic model_check();
        logic [39:0] eb;
        int n;
        n = mq.size();
        for (int i = 0; i < 5; i++) eb[8*i +: 8] = (i < n) ? mq[i] : 8'h90;
        chk("m_dec_valid", 64'(dec_valid), 64'(n > 0));
        chk("m_dec_count", 64'(dec_count), 64'((n > 5) ? 5 : n));
        chk("m_dec_bytes", 64'(dec_bytes), 64'(eb));
        chk("m_dec_pc",    64'(dec_pc),    64'(m_dec_pc));
        chk("m_imem_pc",   64'(imem_pc),   64'(m_fetch_pc));
        chk("m_err_len",   64'(err_len),   64'(m_err));
`ifdef FETCH_PERF_EN
        chk("m_perf",      64'(perf_bubbles), 64'(m_perf));
`else
        chk("m_perf",      64'(perf_bubbles), 64'(0));
`endif
    endtask

    task automatic model_advance();
        int n, vis;
        bit do_fill, legal;
        n       = mq.size();
        vis     = (n > 5) ? 5 : n;
        do_fill = fetch_en && !redirect && (16 - n >= 5);
        legal   = dec_consume && dec_len >= 1 && int'(dec_len) <= vis;
        if (n == 0 && !redirect && m_perf != 32'hFFFF_FFFF) m_perf++;
        if (redirect) begin
            mq.delete();
            m_fetch_pc = redirect_pc;
            m_dec_pc   = redirect_pc;
            m_err      = 1'b0;
        end else begin
            if (legal) begin
                for (int i = 0; i < int'(dec_len); i++) void'(mq.pop_front());
                m_dec_pc = m_dec_pc + 32'(dec_len);
            end else if (dec_consume) begin
                m_err = 1'b1;
            end
            if (do_fill) begin
                for (int i = 0; i < 5; i++) mq.push_back(mem_byte(m_fetch_pc + 32'(i)));
                m_fetch_pc = m_fetch_pc + 32'd5;
            end
        end
    endtask

    task automatic drive(input bit fe, input bit rd, input logic [31:0] rpc,
                         input bit cons, input logic [2:0] len);
        fetch_en    = fe;
        redirect    = rd;
        redirect_pc = rpc;
        dec_consume = cons;
        dec_len     = len;
    endtask

    task automatic step(input bit fe, input bit rd, input logic [31:0] rpc,
                        input bit cons, input logic [2:0] len);
        drive(fe, rd, rpc, cons, len);
        @(negedge clk);
        model_check();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 32'h0, 0, 3'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit          fe;
        bit          rd;
        logic [31:0] rpc;
        bit          cons;
        logic [2:0]  len;
        bit          e_valid;
        logic [2:0]  e_count;
        logic [31:0] e_pc;
        logic [31:0] e_imem;
        logic [39:0] e_bytes;
        bit          e_err;
    } vec_t;

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{1, 0, 32'h0,   0, 3'd0, 0, 3'd0, 32'h0,  32'h0,   40'h90_9090_9090, 0};
        tbl[1]  = '{1, 0, 32'h0,   0, 3'd0, 1, 3'd5, 32'h0,  32'h5,   40'h04_0302_0100, 0};
        tbl[2]  = '{1, 0, 32'h0,   0, 3'd0, 1, 3'd5, 32'h0,  32'hA,   40'h04_0302_0100, 0};
        tbl[3]  = '{1, 0, 32'h0,   0, 3'd0, 1, 3'd5, 32'h0,  32'hF,   40'h04_0302_0100, 0};
        tbl[4]  = '{1, 0, 32'h0,   0, 3'd0, 1, 3'd5, 32'h0,  32'hF,   40'h04_0302_0100, 0};
        tbl[5]  = '{1, 0, 32'h0,   1, 3'd5, 1, 3'd5, 32'h0,  32'hF,   40'h04_0302_0100, 0};
        tbl[6]  = '{1, 0, 32'h0,   0, 3'd0, 1, 3'd5, 32'h5,  32'hF,   40'h09_0807_0605, 0};
        tbl[7]  = '{1, 0, 32'h0,   1, 3'd0, 1, 3'd5, 32'h5,  32'h14,  40'h09_0807_0605, 0};
        tbl[8]  = '{1, 1, 32'h40,  1, 3'd3, 1, 3'd5, 32'h5,  32'h14,  40'h09_0807_0605, 1};
        tbl[9]  = '{1, 0, 32'h0,   0, 3'd0, 0, 3'd0, 32'h40, 32'h40,  40'h90_9090_9090, 0};
        tbl[10] = '{0, 0, 32'h0,   1, 3'd3, 1, 3'd5, 32'h40, 32'h45,  40'h44_4342_4140, 0};
        tbl[11] = '{0, 0, 32'h0,   1, 3'd3, 1, 3'd2, 32'h43, 32'h45,  40'h90_9090_4443, 0};
        tbl[12] = '{0, 1, 32'h100, 0, 3'd0, 1, 3'd2, 32'h43, 32'h45,  40'h90_9090_4443, 1};
        tbl[13] = '{0, 0, 32'h0,   0, 3'd0, 0, 3'd0, 32'h100, 32'h100, 40'h90_9090_9090, 0};

        do_reset();

        // Directed vectors: fill to full, blocked fill on consume, len 0, redirect, overlong len.
        for (int v = 0; v < 14; v++) begin
            drive(tbl[v].fe, tbl[v].rd, tbl[v].rpc, tbl[v].cons, tbl[v].len);
            @(negedge clk);
            model_check();
            chk($sformatf("v%0d_valid", v), 64'(dec_valid), 64'(tbl[v].e_valid));
            chk($sformatf("v%0d_count", v), 64'(dec_count), 64'(tbl[v].e_count));
            chk($sformatf("v%0d_pc", v),    64'(dec_pc),    64'(tbl[v].e_pc));
            chk($sformatf("v%0d_imem", v),  64'(imem_pc),   64'(tbl[v].e_imem));
            chk($sformatf("v%0d_bytes", v), 64'(dec_bytes), 64'(tbl[v].e_bytes));
            chk($sformatf("v%0d_err", v),   64'(err_len),   64'(tbl[v].e_err));
            model_advance();
            @(posedge clk);
            #1;
        end

        // Steady len-3 consumption with refills wrapping the 16-byte queue.
        do_reset();
        repeat (4) step(1, 0, 32'h0, 0, 3'd0);
        for (int c = 0; c < 30; c++) begin
            if (c < 5) begin
                drive(1, 0, 32'h0, 1, 3'd3);
                @(negedge clk);
                chk($sformatf("len3_pc%0d", c), 64'(dec_pc), 64'(3 * c));
                chk($sformatf("len3_b%0d", c), 64'(dec_bytes[7:0]), 64'(3 * c));
                model_check();
                model_advance();
                @(posedge clk);
                #1;
            end else begin
                step(1, 0, 32'h0, 1, 3'd3);
            end
        end

        // Bubble counter with fetch disabled for 7 cycles after reset.
        do_reset();
        repeat (7) step(0, 0, 32'h0, 0, 3'd0);
        drive(0, 0, 32'h0, 0, 3'd0);
        @(negedge clk);
`ifdef FETCH_PERF_EN
        chk("perf_7", 64'(perf_bubbles), 64'(7));
`else
        chk("perf_off", 64'(perf_bubbles), 64'(0));
`endif
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a busy cycle.
        do_reset();
        repeat (6) step(1, 0, 32'h0, 1, 3'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 64'(dec_valid), 64'(0));
        chk("async_imem",  64'(imem_pc),   64'(0));
        chk("async_pc",    64'(dec_pc),    64'(0));
        chk("async_count", 64'(dec_count), 64'(0));
        model_reset();
        drive(0, 0, 32'h0, 0, 3'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized traffic, including redirects near the top of the address space.
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
            step($urandom_range(0, 7) != 0, $urandom_range(0, 24) == 0, rpc,
                 $urandom_range(0, 3) != 0, 3'($urandom_range(0, 5)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
